// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared constants and address-decode helper for the data-side memory system
package mips_mem_pkg;
   localparam logic [15:0] REGION_RAM  = 16'h0000;
   localparam logic [15:0] REGION_MMIO = 16'hFFFF;
   localparam logic [7:0] OFF_COUNT  = 8'h00;
   localparam logic [7:0] OFF_CMP    = 8'h04;
   localparam logic [7:0] OFF_CTRL   = 8'h08;
   localparam logic [7:0] OFF_STATUS = 8'h0C;
   localparam logic [7:0] OFF_GPIO   = 8'h10;
   localparam int CTRL_EN   = 0;
   localparam int CTRL_AUTO = 1;
   localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;
   typedef enum logic [1:0] {RGN_RAM, RGN_MMIO, RGN_NONE} region_t;
   function automatic region_t decode_region(input logic [15:0] tag);
      return tag == REGION_RAM ? RGN_RAM : tag == REGION_MMIO ? RGN_MMIO : RGN_NONE;
   endfunction
endpackage

// File: rtl/data_mem_mmio_if.sv
// data_mem_mmio_if: core-to-memory load/store bus
interface data_mem_mmio_if;
   logic        mem_write;
   logic [31:0] ALU_out;
   logic [31:0] Write_Data;
   logic [31:0] Read_Data;
   modport master (output mem_write, ALU_out, Write_Data, input Read_Data);
   modport slave (input mem_write, ALU_out, Write_Data, output Read_Data);
endinterface

// File: rtl/data_mem_mmio_timer.sv
// mmio_timer: compare timer registers (COUNT, CMP, CTRL, MATCH) with write ports and read mux
module mmio_timer
   import mips_mem_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [7:0]  off,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        match
);
   logic [31:0] count, cmp;
   logic [1:0]  ctrl;
   logic        hit;
   assign hit = ctrl[CTRL_EN] && count == cmp;
   // timer state: software COUNT write beats increment/reload, hardware match beats write-1-to-clear
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         cmp   <= CMP_RESET;
         ctrl  <= '0;
         match <= 1'b0;
      end else begin
         if (we && off == OFF_COUNT) count <= wdata;
         else if (ctrl[CTRL_EN]) count <= (hit && ctrl[CTRL_AUTO]) ? '0 : count + 32'd1;
         if (we && off == OFF_CMP) cmp <= wdata;
         if (we && off == OFF_CTRL) ctrl <= wdata[1:0];
         if (hit) match <= 1'b1;
         else if (we && off == OFF_STATUS && wdata[0]) match <= 1'b0;
      end
   end
   // register read mux; unmapped offsets read zero
   always_comb
      rdata = off == OFF_COUNT  ? count :
              off == OFF_CMP    ? cmp :
              off == OFF_CTRL   ? {30'h0, ctrl} :
              off == OFF_STATUS ? {31'h0, match} : '0;
endmodule

// File: rtl/data_mem_mmio.sv
// data_mem_mmio: word-addressed data RAM plus memory-mapped timer and GPIO for a single-cycle core
module data_mem_mmio
   import mips_mem_pkg::*;
#(
   parameter int RAM_WORDS = 256
) (
   input  logic            CLK,
   input  logic            Reset,
   data_mem_mmio_if.slave  bus,
   output logic            timer_irq,
   output logic [7:0]      gpio_out
);
   localparam int AW = $clog2(RAM_WORDS);
   logic [31:0]   ram [RAM_WORDS];
   region_t       rgn;
   logic [AW-1:0] idx;
   logic [7:0]    off;
   logic [31:0]   timer_rd;
   logic          unused_addr;
   assign rgn = decode_region(bus.ALU_out[31:16]);
   assign idx = bus.ALU_out[AW+1:2];
   assign off = bus.ALU_out[7:0];
   assign unused_addr = ^bus.ALU_out;
   mmio_timer u_timer (
      .clk   (CLK),
      .rst   (Reset),
      .we    (bus.mem_write && rgn == RGN_MMIO),
      .off   (off),
      .wdata (bus.Write_Data),
      .rdata (timer_rd),
      .match (timer_irq)
   );
   // RAM keeps its contents across reset but takes no stores while reset is held
   always_ff @(posedge CLK)
      if (!Reset && bus.mem_write && rgn == RGN_RAM) ram[idx] <= bus.Write_Data;
   // GPIO output register
   always_ff @(posedge CLK)
      if (Reset) gpio_out <= '0;
      else if (bus.mem_write && rgn == RGN_MMIO && off == OFF_GPIO) gpio_out <= bus.Write_Data[7:0];
   // same-cycle load path; a concurrent store is not forwarded
   always_comb
      bus.Read_Data = rgn == RGN_RAM  ? ram[idx] :
                      rgn == RGN_MMIO ? (off == OFF_GPIO ? {24'h0, gpio_out} : timer_rd) : '0;
endmodule

// File: tb/tb_data_mem_mmio.sv
// tb_data_mem_mmio: directed and randomized checks of data_mem_mmio against a behavioural model
module tb_data_mem_mmio;
   logic       CLK = 1'b0;
   logic       Reset = 1'b1;
   logic       timer_irq;
   logic [7:0] gpio_out;
   int         n_cmp = 0;
   int         n_fail = 0;
   logic [31:0] m_count, m_cmp, m_ram [int];
   logic        m_en, m_auto, m_match;
   logic [7:0]  m_gpio;

   data_mem_mmio_if bus ();
   data_mem_mmio #(.RAM_WORDS(256)) dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .bus       (bus),
      .timer_irq (timer_irq),
      .gpio_out  (gpio_out)
   );

   always #5 CLK = ~CLK;

   localparam logic [31:0] A_COUNT = 32'hFFFF_0000, A_CMP = 32'hFFFF_0004, A_CTRL = 32'hFFFF_0008;
   localparam logic [31:0] A_STAT = 32'hFFFF_000C, A_GPIO = 32'hFFFF_0010;

   task automatic model_edge(input logic rst, we, input logic [31:0] a, d);
      logic hit;
      logic [31:0] nc;
      logic nm;
      if (rst) begin
         m_count = 0; m_cmp = 32'hFFFF_FFFF; m_en = 0; m_auto = 0; m_match = 0; m_gpio = 0;
         return;
      end
      hit = m_en && (m_count == m_cmp);
      nc = !m_en ? m_count : (hit && m_auto) ? 32'd0 : m_count + 32'd1;
      nm = m_match;
      if (we && a[31:16] == 16'h0000) m_ram[int'(a[9:2])] = d;
      if (we && a[31:16] == 16'hFFFF) begin
         case (a[7:0])
            8'h00: nc = d;
            8'h04: m_cmp = d;
            8'h08: begin m_en = d[0]; m_auto = d[1]; end
            8'h0C: if (d[0]) nm = 1'b0;
            8'h10: m_gpio = d[7:0];
            default: ;
         endcase
      end
      if (hit) nm = 1'b1;
      m_count = nc;
      m_match = nm;
   endtask

   function automatic bit exp_rd(input logic [31:0] a, output logic [31:0] d);
      d = 32'h0;
      if (a[31:16] == 16'h0000) begin
         if (!m_ram.exists(int'(a[9:2]))) return 0;
         d = m_ram[int'(a[9:2])];
      end else if (a[31:16] == 16'hFFFF) begin
         case (a[7:0])
            8'h00: d = m_count;
            8'h04: d = m_cmp;
            8'h08: d = {30'h0, m_auto, m_en};
            8'h0C: d = {31'h0, m_match};
            8'h10: d = {24'h0, m_gpio};
            default: d = 32'h0;
         endcase
      end
      return 1;
   endfunction

   task automatic tick();
      model_edge(Reset, bus.mem_write, bus.ALU_out, bus.Write_Data);
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, d);
      bus.mem_write = 1'b1; bus.ALU_out = a; bus.Write_Data = d;
      tick();
      bus.mem_write = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      bus.mem_write = 1'b0; bus.ALU_out = a;
      #1;
      d = bus.Read_Data;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      Reset = 1'b1;
      tick(); tick();
      n_cmp += 2;
      if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", timer_irq); end
      if (gpio_out !== 8'h00) begin n_fail++; $display("FAIL reset_gpio got %h want 00", gpio_out); end
      rd(A_COUNT, v); n_cmp++;
      if (v !== 32'h0) begin n_fail++; $display("FAIL reset_count got %h want 0", v); end
      rd(A_CMP, v); n_cmp++;
      if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_cmp got %h want ffffffff", v); end
      rd(A_CTRL, v); n_cmp++;
      if (v !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl got %h want 0", v); end
      Reset = 1'b0;
      tick();
   endtask

   task automatic test_ram_basic();
      logic [31:0] v;
      wr(32'h10, 32'h1111_1111);
      bus.mem_write = 1'b1; bus.ALU_out = 32'h10; bus.Write_Data = 32'hDEAD_BEEF;
      #1; n_cmp++;
      if (bus.Read_Data !== 32'h1111_1111) begin n_fail++; $display("FAIL ram_same_cycle got %h want 11111111", bus.Read_Data); end
      tick();
      bus.mem_write = 1'b0;
      rd(32'h10, v); n_cmp++;
      if (v !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_rd10 got %h want deadbeef", v); end
      rd(32'h13, v); n_cmp++;
      if (v !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_rd13 got %h want deadbeef", v); end
   endtask

   task automatic test_alias();
      logic [31:0] v;
      wr(32'h0, 32'h1);
      rd(32'h400, v); n_cmp++;
      if (v !== 32'h1) begin n_fail++; $display("FAIL ram_alias got %h want 1", v); end
      wr(32'h1234_0000, 32'hCAFE_F00D);
      rd(32'h1234_0000, v); n_cmp++;
      if (v !== 32'h0) begin n_fail++; $display("FAIL other_region got %h want 0", v); end
      rd(32'h0, v); n_cmp++;
      if (v !== 32'h1) begin n_fail++; $display("FAIL other_region_no_ram got %h want 1", v); end
   endtask

   task automatic test_timer_run();
      logic [31:0] v;
      wr(A_CMP, 32'd5);
      wr(A_CTRL, 32'd3);
      for (int i = 0; i < 14; i++) begin
         rd(A_COUNT, v); n_cmp += 2;
         if (v !== 32'(i % 6)) begin n_fail++; $display("FAIL run_count[%0d] got %0d want %0d", i, v, i % 6); end
         if (timer_irq !== (i >= 6)) begin n_fail++; $display("FAIL run_irq[%0d] got %b want %b", i, timer_irq, i >= 6); end
         tick();
      end
   endtask

   task automatic test_wrap();
      logic [31:0] v;
      wr(A_CTRL, 32'd0);
      wr(A_COUNT, 32'hFFFF_FFFE);
      wr(A_CMP, 32'd3);
      wr(A_STAT, 32'd1);
      wr(A_CTRL, 32'd1);
      rd(A_COUNT, v); n_cmp++;
      if (v !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL wrap_start got %h want fffffffe", v); end
      tick(); tick();
      rd(A_COUNT, v); n_cmp++;
      if (v !== 32'h0) begin n_fail++; $display("FAIL wrap_count got %h want 0", v); end
      rd(A_STAT, v); n_cmp++;
      if (v !== 32'h0) begin n_fail++; $display("FAIL wrap_match got %h want 0", v); end
   endtask

   task automatic test_w1c_priority();
      logic [31:0] v;
      wr(A_CTRL, 32'd0);
      wr(A_COUNT, 32'd0);
      wr(A_CMP, 32'd2);
      wr(A_STAT, 32'd1);
      wr(A_CTRL, 32'd3);
      tick(); tick(); tick();
      rd(A_COUNT, v); n_cmp += 2;
      if (v !== 32'd0 || timer_irq !== 1'b1) begin n_fail++; $display("FAIL w1c_first_match got count=%0d irq=%b want 0/1", v, timer_irq); end
      tick(); tick();
      rd(A_COUNT, v);
      if (v !== 32'd2) begin n_fail++; $display("FAIL w1c_at_cmp got %0d want 2", v); end
      wr(A_STAT, 32'd1);
      n_cmp++;
      if (timer_irq !== 1'b1) begin n_fail++; $display("FAIL w1c_set_wins got %b want 1", timer_irq); end
      wr(A_STAT, 32'd1);
      rd(A_STAT, v); n_cmp += 2;
      if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL w1c_clear got %b want 0", timer_irq); end
      if (v !== 32'h0) begin n_fail++; $display("FAIL w1c_status got %h want 0", v); end
   endtask

   task automatic test_gpio_reset();
      logic [31:0] v;
      wr(A_GPIO, 32'h1A5);
      rd(A_GPIO, v); n_cmp += 2;
      if (gpio_out !== 8'hA5) begin n_fail++; $display("FAIL gpio_out got %h want a5", gpio_out); end
      if (v !== 32'hA5) begin n_fail++; $display("FAIL gpio_rd got %h want a5", v); end
      Reset = 1'b1;
      wr(A_GPIO, 32'hFF);
      n_cmp += 2;
      if (gpio_out !== 8'h00) begin n_fail++; $display("FAIL rst_gpio got %h want 00", gpio_out); end
      if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq got %b want 0", timer_irq); end
      rd(A_COUNT, v); n_cmp++;
      if (v !== 32'h0) begin n_fail++; $display("FAIL rst_count got %h want 0", v); end
      rd(A_CMP, v); n_cmp++;
      if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rst_cmp got %h want ffffffff", v); end
      wr(32'h10, 32'h5555_5555);
      Reset = 1'b0;
      rd(32'h10, v); n_cmp++;
      if (v !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rst_ram_keep got %h want deadbeef", v); end
      tick(); tick();
      rd(A_COUNT, v); n_cmp++;
      if (v !== 32'h0) begin n_fail++; $display("FAIL rst_timer_stopped got %h want 0", v); end
   endtask

   task automatic test_random();
      logic [31:0] a, d, e;
      logic [7:0] offs [7] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20};
      logic [7:0] o;
      for (int i = 0; i < 400; i++) begin
         o = offs[$urandom_range(0, 6)];
         d = $urandom;
         case ($urandom_range(0, 5))
            0, 1: a = {20'h0, 12'($urandom)};
            2, 3: begin
               a = {24'hFFFF_00, o};
               if (o == 8'h00 || o == 8'h04) d = $urandom_range(0, 12);
            end
            4: a = {16'($urandom_range(1, 16'hFFFE)), 16'($urandom)};
            default: a = A_COUNT;
         endcase
         Reset = ($urandom_range(0, 79) == 0);
         bus.mem_write = $urandom_range(0, 1) == 1; bus.ALU_out = a; bus.Write_Data = d;
         #1;
         if (exp_rd(a, e)) begin
            n_cmp++;
            if (bus.Read_Data !== e) begin n_fail++; $display("FAIL rnd_rd[%0d] addr %h got %h want %h", i, a, bus.Read_Data, e); end
         end
         n_cmp += 2;
         if (timer_irq !== m_match) begin n_fail++; $display("FAIL rnd_irq[%0d] got %b want %b", i, timer_irq, m_match); end
         if (gpio_out !== m_gpio) begin n_fail++; $display("FAIL rnd_gpio[%0d] got %h want %h", i, gpio_out, m_gpio); end
         tick();
      end
      Reset = 1'b0;
      bus.mem_write = 1'b0;
   endtask

   initial begin
      bus.mem_write = 1'b0; bus.ALU_out = 32'h0; bus.Write_Data = 32'h0;
      test_reset();
      test_ram_basic();
      test_alias();
      test_timer_run();
      test_wrap();
      test_w1c_priority();
      test_gpio_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
